// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter, its two requesters (CPU, loader) and the memory port.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface mem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 14
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_add;
    logic [DW-1:0] cpu_din;
    logic          cpu_gnt;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_add;
    logic [DW-1:0] ld_din;
    logic          ld_gnt;
    logic          ld_ack;
    logic [DW-1:0] ld_dout;

    logic          mem_en;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_add, cpu_din,
        output cpu_gnt, cpu_ack, cpu_dout,
        input  ld_req, ld_we, ld_add, ld_din,
        output ld_gnt, ld_ack, ld_dout,
        output mem_en, mem_add, mem_din,
        input  mem_dout,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_add, cpu_din,
        input  cpu_gnt, cpu_ack, cpu_dout,
        output ld_req, ld_we, ld_add, ld_din,
        input  ld_gnt, ld_ack, ld_dout,
        input  mem_en, mem_add, mem_din,
        output mem_dout,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU / loader) for the single-port 32x14 memory.
// Every access runs IDLE -> ISSUE -> WAIT -> DONE, one access per four cycles.
//
//   state | meaning
//   IDLE  | sample cpu_req/ld_req, pick a winner, latch its we/add/din
//   ISSUE | winner's gnt high, memory port driven (mem_en = latched we)
//   WAIT  | memory read data valid; captured into winner's dout on reads
//   DONE  | winner's ack pulses, then back to IDLE
module mem_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 14,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic CPU    = 1'b0;
    localparam logic LOADER = 1'b1;

    state_t        state;
    state_t        state_nxt;
    logic          last_winner;
    logic          we_q;
    logic [AW-1:0] add_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] cpu_dout_q;
    logic [DW-1:0] ld_dout_q;
    logic          any_req;
    logic          pick_ld;

    assign any_req = bus.cpu_req | bus.ld_req;
    // Loader wins when alone, on every tie with FIXED_PRIO, or on a tie when the CPU went last.
    assign pick_ld = bus.ld_req & (~bus.cpu_req | FIXED_PRIO | (last_winner == CPU));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_winner doubles as the owner of the transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= LOADER;
            we_q        <= 1'b0;
            add_q       <= '0;
            din_q       <= '0;
            cpu_dout_q  <= '0;
            ld_dout_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_winner <= pick_ld;
                if (pick_ld) begin
                    we_q  <= bus.ld_we;
                    add_q <= bus.ld_add;
                    din_q <= bus.ld_din;
                end else begin
                    we_q  <= bus.cpu_we;
                    add_q <= bus.cpu_add;
                    din_q <= bus.cpu_din;
                end
            end
            if (state == WAIT && !we_q) begin
                if (last_winner == LOADER) ld_dout_q  <= bus.mem_dout;
                else                       cpu_dout_q <= bus.mem_dout;
            end
        end
    end

    always_comb begin
        bus.cpu_gnt = 1'b0;
        bus.ld_gnt  = 1'b0;
        bus.cpu_ack = 1'b0;
        bus.ld_ack  = 1'b0;
        bus.mem_en  = 1'b0;
        bus.busy    = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.cpu_gnt = (last_winner == CPU);
                bus.ld_gnt  = (last_winner == LOADER);
                bus.mem_en  = we_q;
            end
            DONE: begin
                bus.cpu_ack = (last_winner == CPU);
                bus.ld_ack  = (last_winner == LOADER);
            end
            default: ;
        endcase
    end

    assign bus.mem_add  = add_q;
    assign bus.mem_din  = din_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.ld_dout  = ld_dout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences
// and a random two-requester stream against a reference memory.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if #(.AW(5), .DW(14)) i0 ();
    mem_arbiter_if #(.AW(5), .DW(14)) i1 ();

    mem_arbiter #(.AW(5), .DW(14), .FIXED_PRIO(1'b0)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(i0));
    mem_arbiter #(.AW(5), .DW(14), .FIXED_PRIO(1'b1)) u_fix (.clk(clk), .rst_n(rst_n), .bus(i1));

    // Fixed-priority instance sees exactly the same request stimulus.
    assign i1.cpu_req = i0.cpu_req;
    assign i1.cpu_we  = i0.cpu_we;
    assign i1.cpu_add = i0.cpu_add;
    assign i1.cpu_din = i0.cpu_din;
    assign i1.ld_req  = i0.ld_req;
    assign i1.ld_we   = i0.ld_we;
    assign i1.ld_add  = i0.ld_add;
    assign i1.ld_din  = i0.ld_din;

    logic [13:0] mem0    [32];
    logic [13:0] mem1    [32];
    logic [13:0] ref_mem [32];

    always @(posedge clk) begin
        if (i0.mem_en) mem0[i0.mem_add] <= i0.mem_din;
        i0.mem_dout <= mem0[i0.mem_add];
        if (i1.mem_en) mem1[i1.mem_add] <= i1.mem_din;
        i1.mem_dout <= mem1[i1.mem_add];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [4:0]  cpu_add;
        logic [13:0] cpu_din;
        logic        ld_req;
        logic        ld_we;
        logic [4:0]  ld_add;
        logic [13:0] ld_din;
        int          win;          // 0 none, 1 cpu, 2 loader
        logic [13:0] exp_cpu_dout;
        logic [13:0] exp_ld_dout;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        i0.cpu_req = 1'b0;
        i0.ld_req  = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        logic        exp_en;
        logic [4:0]  exp_add;
        logic [13:0] exp_din;
        v = vecs[idx];
        i0.cpu_req = v.cpu_req; i0.cpu_we = v.cpu_we; i0.cpu_add = v.cpu_add; i0.cpu_din = v.cpu_din;
        i0.ld_req  = v.ld_req;  i0.ld_we  = v.ld_we;  i0.ld_add  = v.ld_add;  i0.ld_din  = v.ld_din;
        tick();
        drop_reqs();
        if (v.win == 0) begin
            chk($sformatf("v%0d_idle_busy", idx), 32'(i0.busy), 32'(0));
            chk($sformatf("v%0d_idle_gnt", idx), 32'(i0.cpu_gnt | i0.ld_gnt), 32'(0));
        end else begin
            exp_en  = (v.win == 2) ? v.ld_we  : v.cpu_we;
            exp_add = (v.win == 2) ? v.ld_add : v.cpu_add;
            exp_din = (v.win == 2) ? v.ld_din : v.cpu_din;
            chk($sformatf("v%0d_cpu_gnt", idx), 32'(i0.cpu_gnt), 32'(v.win == 1));
            chk($sformatf("v%0d_ld_gnt", idx), 32'(i0.ld_gnt), 32'(v.win == 2));
            chk($sformatf("v%0d_mem_add", idx), 32'(i0.mem_add), 32'(exp_add));
            chk($sformatf("v%0d_mem_en", idx), 32'(i0.mem_en), 32'(exp_en));
            if (exp_en) chk($sformatf("v%0d_mem_din", idx), 32'(i0.mem_din), 32'(exp_din));
            chk($sformatf("v%0d_busy1", idx), 32'(i0.busy), 32'(1));
            tick();
            chk($sformatf("v%0d_wait_en", idx), 32'(i0.mem_en), 32'(0));
            chk($sformatf("v%0d_wait_gnt", idx), 32'(i0.cpu_gnt | i0.ld_gnt), 32'(0));
            tick();
            chk($sformatf("v%0d_cpu_ack", idx), 32'(i0.cpu_ack), 32'(v.win == 1));
            chk($sformatf("v%0d_ld_ack", idx), 32'(i0.ld_ack), 32'(v.win == 2));
            chk($sformatf("v%0d_busy3", idx), 32'(i0.busy), 32'(1));
            tick();
            chk($sformatf("v%0d_busy4", idx), 32'(i0.busy), 32'(0));
            chk($sformatf("v%0d_ack4", idx), 32'(i0.cpu_ack | i0.ld_ack), 32'(0));
        end
        chk($sformatf("v%0d_cpu_dout", idx), 32'(i0.cpu_dout), 32'(v.exp_cpu_dout));
        chk($sformatf("v%0d_ld_dout", idx), 32'(i0.ld_dout), 32'(v.exp_ld_dout));
    endtask

    int          cpu_wait, ld_wait;
    logic        cpu_pend, ld_pend;
    logic [13:0] cpu_exp, ld_exp;
    int          n_hi;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        i0.cpu_req = 1'b0; i0.cpu_we = 1'b0; i0.cpu_add = '0; i0.cpu_din = '0;
        i0.ld_req  = 1'b0; i0.ld_we  = 1'b0; i0.ld_add  = '0; i0.ld_din  = '0;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 14'h2000 | 14'(i);
            mem1[i] = 14'h2000 | 14'(i);
        end
        mem0[5] = 14'h1A3C;
        mem1[5] = 14'h1A3C;

        //             creq  cwe   cadd   cdin      lreq  lwe   ladd    ldin      win cpu_dout  ld_dout
        vecs[0] = '{1'b1, 1'b0, 5'd5,  14'h0000, 1'b0, 1'b0, 5'd0,  14'h0000, 1, 14'h1A3C, 14'h0000};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  14'h0000, 1'b1, 1'b1, 5'd31, 14'h3FFF, 2, 14'h1A3C, 14'h0000};
        vecs[2] = '{1'b1, 1'b0, 5'd31, 14'h0000, 1'b0, 1'b0, 5'd0,  14'h0000, 1, 14'h3FFF, 14'h0000};
        vecs[3] = '{1'b1, 1'b0, 5'd3,  14'h0000, 1'b1, 1'b0, 5'd10, 14'h0000, 2, 14'h3FFF, 14'h200A};
        vecs[4] = '{1'b1, 1'b0, 5'd0,  14'h0000, 1'b1, 1'b0, 5'd5,  14'h0000, 1, 14'h2000, 14'h200A};
        vecs[5] = '{1'b1, 1'b1, 5'd0,  14'h1555, 1'b0, 1'b0, 5'd0,  14'h0000, 1, 14'h2000, 14'h200A};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  14'h0000, 1'b1, 1'b0, 5'd0,  14'h0000, 2, 14'h2000, 14'h1555};
        vecs[7] = '{1'b0, 1'b0, 5'd9,  14'h0000, 1'b0, 1'b1, 5'd9,  14'h1111, 0, 14'h2000, 14'h1555};
        vecs[8] = '{1'b1, 1'b1, 5'd7,  14'h0ABC, 1'b1, 1'b1, 5'd7,  14'h3333, 1, 14'h2000, 14'h1555};
        vecs[9] = '{1'b0, 1'b0, 5'd0,  14'h0000, 1'b1, 1'b0, 5'd7,  14'h0000, 2, 14'h2000, 14'h0ABC};

        // Reset state
        #13;
        chk("rst_busy", 32'(i0.busy), 32'(0));
        chk("rst_gnt", 32'({i0.cpu_gnt, i0.ld_gnt}), 32'(0));
        chk("rst_ack", 32'({i0.cpu_ack, i0.ld_ack}), 32'(0));
        chk("rst_mem_en", 32'(i0.mem_en), 32'(0));
        chk("rst_mem_add", 32'(i0.mem_add), 32'(0));
        chk("rst_mem_din", 32'(i0.mem_din), 32'(0));
        chk("rst_douts", 32'({i0.cpu_dout, i0.ld_dout}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i);

        // 1-cycle loader request during a CPU transaction is never sampled
        i0.cpu_req = 1'b1; i0.cpu_we = 1'b0; i0.cpu_add = 5'd5;
        tick();
        chk("wd_cpu_gnt", 32'(i0.cpu_gnt), 32'(1));
        i0.cpu_req = 1'b0;
        i0.ld_req = 1'b1; i0.ld_we = 1'b0; i0.ld_add = 5'd3;
        tick();
        i0.ld_req = 1'b0;
        chk("wd_ld_gnt2", 32'(i0.ld_gnt), 32'(0));
        tick();
        chk("wd_cpu_ack", 32'(i0.cpu_ack), 32'(1));
        chk("wd_cpu_dout", 32'(i0.cpu_dout), 32'(14'h1A3C));
        for (int k = 4; k < 8; k++) begin
            tick();
            chk($sformatf("wd_ld_quiet%0d", k), 32'({i0.ld_gnt, i0.ld_ack, i0.busy}), 32'(0));
        end

        // Continuous tie from reset: round-robin alternates, fixed priority always loader
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        i0.cpu_req = 1'b1; i0.cpu_we = 1'b0; i0.cpu_add = 5'd1;
        i0.ld_req  = 1'b1; i0.ld_we  = 1'b0; i0.ld_add  = 5'd2;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) drop_reqs();
            chk($sformatf("tie_rr_cpu_gnt%0d", k), 32'(i0.cpu_gnt), 32'(k % 8 == 1));
            chk($sformatf("tie_rr_cpu_ack%0d", k), 32'(i0.cpu_ack), 32'(k % 8 == 3));
            chk($sformatf("tie_rr_ld_gnt%0d", k), 32'(i0.ld_gnt), 32'(k % 8 == 5));
            chk($sformatf("tie_rr_ld_ack%0d", k), 32'(i0.ld_ack), 32'(k % 8 == 7));
            chk($sformatf("tie_rr_busy%0d", k), 32'(i0.busy), 32'(k % 4 != 0));
            chk($sformatf("tie_fx_ld_gnt%0d", k), 32'(i1.ld_gnt), 32'(k % 4 == 1));
            chk($sformatf("tie_fx_ld_ack%0d", k), 32'(i1.ld_ack), 32'(k % 4 == 3));
            chk($sformatf("tie_fx_cpu%0d", k), 32'({i1.cpu_gnt, i1.cpu_ack}), 32'(0));
            if (k == 3) chk("tie_rr_cpu_dout", 32'(i0.cpu_dout), 32'(14'h2001));
            if (k == 7) chk("tie_rr_ld_dout", 32'(i0.ld_dout), 32'(14'h2002));
            if (k == 3) chk("tie_fx_ld_dout", 32'(i1.ld_dout), 32'(14'h2002));
        end
        tick();

        // Async reset in WAIT clears everything within the cycle
        i0.cpu_req = 1'b1; i0.cpu_we = 1'b0; i0.cpu_add = 5'd9;
        tick();
        drop_reqs();
        chk("ar_cpu_gnt", 32'(i0.cpu_gnt), 32'(1));
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_ctrl", 32'({i0.cpu_gnt, i0.ld_gnt, i0.cpu_ack, i0.ld_ack, i0.mem_en, i0.busy}), 32'(0));
        chk("ar_mem_add", 32'(i0.mem_add), 32'(0));
        chk("ar_cpu_dout", 32'(i0.cpu_dout), 32'(0));
        chk("ar_ld_dout", 32'(i0.ld_dout), 32'(0));
        tick();
        chk("ar_no_ack", 32'(i0.cpu_ack), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        i0.cpu_req = 1'b1; i0.cpu_we = 1'b0; i0.cpu_add = 5'd5;
        i0.ld_req  = 1'b1; i0.ld_we  = 1'b0; i0.ld_add  = 5'd6;
        tick();
        drop_reqs();
        chk("ar_tie_cpu_gnt", 32'(i0.cpu_gnt), 32'(1));
        chk("ar_tie_ld_gnt", 32'(i0.ld_gnt), 32'(0));
        tick();
        tick();
        chk("ar_tie_cpu_ack", 32'(i0.cpu_ack), 32'(1));
        chk("ar_tie_cpu_dout", 32'(i0.cpu_dout), 32'(14'h1A3C));
        tick();

        // Random two-requester stream against a reference memory
        for (int i = 0; i < 32; i++) ref_mem[i] = mem0[i];
        cpu_exp = 14'h1A3C;
        ld_exp  = 14'h0000;
        cpu_pend = 1'b0; ld_pend = 1'b0;
        cpu_wait = 0;    ld_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            n_hi = int'(i0.cpu_gnt) + int'(i0.ld_gnt) + int'(i0.cpu_ack) + int'(i0.ld_ack);
            chk("rnd_excl", 32'(n_hi <= 1), 32'(1));
            if (i0.cpu_ack) begin
                chk("rnd_cpu_ack_expected", 32'(cpu_pend), 32'(1));
                if (cpu_pend && !i0.cpu_we) cpu_exp = ref_mem[i0.cpu_add];
                if (cpu_pend && i0.cpu_we)  ref_mem[i0.cpu_add] = i0.cpu_din;
                cpu_pend = 1'b0; i0.cpu_req = 1'b0; cpu_wait = 0;
            end else if (cpu_pend) begin
                cpu_wait++;
                if (cpu_wait > 12) begin
                    chk("rnd_cpu_timeout", 32'(cpu_wait), 32'(0));
                    cpu_pend = 1'b0; i0.cpu_req = 1'b0; cpu_wait = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i0.cpu_we  = 1'($urandom_range(0, 1));
                i0.cpu_add = 5'($urandom_range(0, 31));
                i0.cpu_din = 14'($urandom_range(0, 16383));
                i0.cpu_req = 1'b1; cpu_pend = 1'b1;
            end
            if (i0.ld_ack) begin
                chk("rnd_ld_ack_expected", 32'(ld_pend), 32'(1));
                if (ld_pend && !i0.ld_we) ld_exp = ref_mem[i0.ld_add];
                if (ld_pend && i0.ld_we)  ref_mem[i0.ld_add] = i0.ld_din;
                ld_pend = 1'b0; i0.ld_req = 1'b0; ld_wait = 0;
            end else if (ld_pend) begin
                ld_wait++;
                if (ld_wait > 12) begin
                    chk("rnd_ld_timeout", 32'(ld_wait), 32'(0));
                    ld_pend = 1'b0; i0.ld_req = 1'b0; ld_wait = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i0.ld_we  = 1'($urandom_range(0, 1));
                i0.ld_add = 5'($urandom_range(0, 31));
                i0.ld_din = 14'($urandom_range(0, 16383));
                i0.ld_req = 1'b1; ld_pend = 1'b1;
            end
            chk("rnd_cpu_dout", 32'(i0.cpu_dout), 32'(cpu_exp));
            chk("rnd_ld_dout", 32'(i0.ld_dout), 32'(ld_exp));
        end
        drop_reqs();
        for (int k = 0; k < 10; k++) tick();
        chk("end_idle", 32'(i0.busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single 32x14 program/data memory between two requesters: the CPU control path and an external program loader/debug port.
- Sits between both requesters and the memory's clk/en/add/datain/dout port.
- Serializes accesses through a 4-state sequencer with req/gnt/ack handshakes.
- Ties are resolved round-robin, or by fixed loader priority when selected by parameter.

Parameters:
AW, 5, memory address width (32 words)
DW, 14, memory data width (instruction/operand word)
FIXED_PRIO, 0, 0 = round-robin on ties; 1 = loader always wins ties

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; valid while cpu_req
cpu_add  in  AW  CPU address
cpu_din  in  DW  CPU write data
cpu_gnt  out  1  CPU owns memory port this cycle (ISSUE state)
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_dout  out  DW  CPU read data, valid with cpu_ack on reads
ld_req  in  1  loader access request, held until ld_ack
ld_we  in  1  loader write enable
ld_add  in  AW  loader address
ld_din  in  DW  loader write data
ld_gnt  out  1  loader owns memory port this cycle
ld_ack  out  1  one-cycle completion pulse to loader
ld_dout  out  DW  loader read data, valid with ld_ack on reads
mem_en  out  1  memory write enable
mem_add  out  AW  memory address
mem_din  out  DW  memory write data
mem_dout  in  DW  memory synchronous read data (1-cycle latency)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all gnt/ack/mem_en/busy=0.
  - mem_add, mem_din, cpu_dout and ld_dout = 0.
  - last_winner=LOADER, so the CPU wins the first tie.
- Reset asserted mid-transaction aborts it immediately. No ack is issued and mem_en drops asynchronously. A write in flight may or may not have committed.
- States and transitions:
  - IDLE: sample cpu_req/ld_req.
    - Neither set: stay.
    - One set: it wins.
    - Both set, FIXED_PRIO=0: the winner is the requester not equal to last_winner.
    - Both set, FIXED_PRIO=1: loader wins.
    - On a winner: latch the winner's we/add/din into mem_add, mem_din and a we register; update last_winner; go to ISSUE.
  - ISSUE (1 cycle): winner's gnt=1; mem_en=latched we; mem_add/mem_din drive the latched values. Memory samples at the end of this cycle. Go to WAIT.
  - WAIT (1 cycle): mem_en=0. mem_dout now holds the read value; on a read, capture it into the winner's dout register. Go to DONE.
  - DONE (1 cycle): winner's ack=1; go to IDLE.
- Latency: request seen in IDLE at cycle N → gnt at N+1 → ack at N+3. Next arbitration in IDLE at N+4; maximum throughput is 1 access per 4 cycles.
- Requester protocol:
  - Requester deasserts req in the ack cycle or later.
  - If req is still high when IDLE is re-entered, it is treated as a new request.
  - Request inputs are sampled only in IDLE. Changes to we/add/din after that are ignored until the next IDLE.
- Req dropped before ack: the transaction still completes and ack still pulses.
- Write accesses: ack pulses, and the winner's dout register is unchanged. The loser's dout never changes.
- gnt and ack are mutually exclusive between requesters; at most one of cpu_gnt/ld_gnt/cpu_ack/ld_ack is high per cycle.
- Addresses pass through unmodified. There is no wrap logic; AW bits cover the whole memory.
- Starvation bound: with FIXED_PRIO=0 and both requesting continuously, grants strictly alternate, so each requester waits at most 8 cycles.

Test Plan:
- Reset then CPU read: preload mem[5]=14'h1A3C; assert cpu_req, cpu_we=0, cpu_add=5 at N → cpu_gnt=1 at N+1 with mem_add=5, mem_en=0; cpu_ack=1 at N+3 with cpu_dout=14'h1A3C; busy=1 from N+1 to N+3.
- Loader write then CPU read-back: ld_req, ld_we=1, ld_add=31, ld_din=14'h3FFF → mem_en=1 only at N+1, ld_ack at N+3, ld_dout unchanged. CPU then reads addr 31 → cpu_dout=14'h3FFF.
- Simultaneous requests held continuously, FIXED_PRIO=0: grant order is CPU, LD, CPU, LD, with acks at N+3, N+7, N+11, N+15. With FIXED_PRIO=1, the loader wins every tie.
- Request withdrawn: cpu_req pulses for 1 cycle in IDLE → full transaction still runs and cpu_ack pulses at N+3. A 1-cycle ld_req during a busy CPU transaction is not sampled and gets no grant.
- Async reset mid-transaction: rst_n=0 during WAIT → all outputs are 0 within the same cycle. After release, the first tie goes to the CPU.
- Mutual exclusion: random req/we/add stream over 2000 cycles with a memory model → never two gnt/ack high at once. Every read ack returns the model value, and every accepted request gets exactly one ack.
